csi_rx_link_ctrl: RTL and testbench
===================================

CSI_RX_LINK_CTRL -- requirements
Module: csi_rx_link_ctrl

Interface
REQ-001 Parameter LP_SETTLE, default 16: consecutive lp_detect cycles required to arm the link.
REQ-002 Parameter RESYNC_CYCLES, default 8: length of the rx_reset pulse issued on flush.
REQ-003 Parameter FRAME_TIMEOUT, default 24'd1000000: maximum enabled cycles inside a frame with no payload_enable and no vsync.
REQ-004 Parameter EXP_LINES, default 16'd0: expected lines per frame; 0 disables the check.
REQ-005 Port list, one per line:
- clock  in  1  byte/word clock; the only clock.
- reset_n  in  1  synchronous, active-low reset.
- enable  in  1  active-high clock enable.
- lp_detect  in  1  D-PHY LP-mode detect.
- vsync  in  1  frame-start pulse from the packet handler.
- in_frame  in  1  in-frame level from the packet handler.
- in_line  in  1  in-line level from the packet handler.
- payload_enable  in  1  payload valid from the packet handler.
- err_clear  in  1  clears sticky error flags.
- rx_reset  out  1  active-high sync reset to the packet handler and aligners.
- frame_active  out  1  high in state FRAME.
- frame_done  out  1  one-cycle pulse on a good frame end.
- line_count  out  16  lines counted in the current frame.
- last_line_count  out  16  line_count captured at the last frame end.
- frame_count  out  16  completed frames, wraps 16'hFFFF->0.
- err_timeout, err_lines, err_seq  out  1 each  sticky error flags.

Function
REQ-010 All outputs SHALL be registered; nothing SHALL change while enable=0, except reset.
REQ-011 FSM states SHALL be FLUSH, ARM, WAIT_FS and FRAME.
REQ-012 FLUSH SHALL hold rx_reset=1 for RESYNC_CYCLES enabled cycles, then go to ARM with rx_reset=0.
REQ-013 ARM SHALL count consecutive lp_detect=1 cycles and reset the count on lp_detect=0; at count LP_SETTLE it SHALL go to WAIT_FS.
REQ-014 WAIT_FS SHALL wait without a timeout; vsync=1 SHALL go to FRAME, clear line_count and clear the watchdog.
REQ-015 In FRAME, each 0->1 edge of in_line SHALL increment line_count, saturating at 16'hFFFF.
REQ-016 In FRAME, the watchdog SHALL increment every enabled cycle and clear on payload_enable=1 or vsync=1; on reaching FRAME_TIMEOUT it SHALL set err_timeout and go to FLUSH.
REQ-017 In FRAME, a 1->0 edge of in_frame SHALL:
- capture last_line_count;
- increment frame_count;
- set err_lines if EXP_LINES!=0 and line_count!=EXP_LINES;
- pulse frame_done only if no line error;
- go to WAIT_FS.
REQ-018 vsync=1 in FRAME (FS without FE) SHALL set err_seq, restart line_count at 0, clear the watchdog and stay in FRAME; frame_count SHALL not change.
REQ-019 A line edge and a frame end in the same cycle SHALL count the line before the capture.
REQ-020 Timeout and frame end in the same cycle: timeout SHALL win, with no frame_done and no frame_count change.
REQ-021 err_clear SHALL clear all sticky flags; an error set in the same cycle SHALL win.
REQ-022 lp_detect SHALL NOT affect FRAME or WAIT_FS, because LP between packets is legal.

Reset
REQ-030 While reset_n=0 at a clock edge, regardless of enable:
- state=FLUSH with the flush counter at 0, and rx_reset=1;
- all counters, flags and frame_done=0, frame_active=0.
REQ-031 Reset asserted mid-frame SHALL abandon the frame without a frame_done pulse or a frame_count change.

Structure
REQ-040 The FSM state encoding and the counter widths (16-bit line and frame counts, 24-bit watchdog) SHALL live in the shared package csi_rx_pkg.
REQ-041 The design SHALL contain one sub-module, csi_rx_watchdog: a loadable up-counter with clear and terminal-count output, reused for the flush, LP-settle and timeout counts.

Verification
REQ-050 Release reset -> rx_reset=1 for exactly 8 cycles; lp_detect held 16 cycles -> WAIT_FS; 15 cycles then a 0 -> stays in ARM.
REQ-051 EXP_LINES=4: vsync, four in_line pulses, in_frame fall -> last_line_count=4, frame_count=1, frame_done pulse, no errors.
REQ-052 EXP_LINES=4, three lines -> err_lines=1, frame_count=1, no frame_done.
REQ-053 FRAME_TIMEOUT=100, in FRAME with no payload for 100 cycles -> err_timeout=1, then an 8-cycle rx_reset, then ARM.
REQ-054 Second vsync mid-frame after 2 lines -> err_seq=1, line_count=0, frame_count unchanged.
REQ-055 enable=0 for 50 cycles mid-frame -> all outputs frozen, watchdog not advanced; reset_n=0 mid-frame -> rx_reset=1, frame_count=0.

Source files
------------

// File: rtl/csi_rx_pkg.sv
// Shared definitions for the CSI-2 receive link controller: FSM encoding,
// counter widths and a saturating increment helper.
package csi_rx_pkg;

    localparam int LINE_W  = 16;
    localparam int FRAME_W = 16;
    localparam int WDOG_W  = 24;

    typedef enum logic [1:0] {
        ST_FLUSH   = 2'd0,
        ST_ARM     = 2'd1,
        ST_WAIT_FS = 2'd2,
        ST_FRAME   = 2'd3
    } link_state_t;

    // Line counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [LINE_W-1:0] line_sat_inc(input logic [LINE_W-1:0] value);
        logic [LINE_W-1:0] result;
        if (value == {LINE_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + {{(LINE_W-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

endpackage

// File: rtl/csi_rx_watchdog.sv
// Loadable up-counter with clear and a "next increment reaches terminal"
// flag. One instance serves the flush, LP-settle and frame-timeout counts,
// since those phases never overlap.
import csi_rx_pkg::*;

module csi_rx_watchdog #(
    parameter int W = WDOG_W
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         enable,
    input  logic         clear,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic [W-1:0] terminal,
    output logic         tc
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] count_r;

    // tc is raised while the count sits one short of terminal, so the
    // controller can act on the same edge the count would reach it.
    assign tc = ((count_r + ONE) == terminal);

    // Count register: clear beats load beats increment; frozen while disabled.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_r <= {W{1'b0}};
        end else if (enable) begin
            if (clear) begin
                count_r <= {W{1'b0}};
            end else if (load) begin
                count_r <= load_value;
            end else if (inc) begin
                count_r <= count_r + ONE;
            end
        end
    end

endmodule

// File: rtl/csi_rx_link_ctrl.sv
// CSI-2 receive link controller: flushes the receive path, waits for the
// lane to settle in LP mode, then tracks frames/lines and flags timeouts,
// line-count mismatches and frame-start/frame-end sequencing errors.
import csi_rx_pkg::*;

module csi_rx_link_ctrl #(
    parameter int unsigned       LP_SETTLE     = 16,
    parameter int unsigned       RESYNC_CYCLES = 8,
    parameter logic [WDOG_W-1:0] FRAME_TIMEOUT = 24'd1000000,
    parameter logic [LINE_W-1:0] EXP_LINES     = 16'd0
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               lp_detect,
    input  logic               vsync,
    input  logic               in_frame,
    input  logic               in_line,
    input  logic               payload_enable,
    input  logic               err_clear,
    output logic               rx_reset,
    output logic               frame_active,
    output logic               frame_done,
    output logic [LINE_W-1:0]  line_count,
    output logic [LINE_W-1:0]  last_line_count,
    output logic [FRAME_W-1:0] frame_count,
    output logic               err_timeout,
    output logic               err_lines,
    output logic               err_seq
);

    link_state_t        state_r, state_next_s;
    logic               in_line_q_r, in_frame_q_r;
    logic               wd_clear_s, wd_inc_s, wd_tc_s;
    logic [WDOG_W-1:0]  wd_terminal_s;
    logic               line_rise_s, frame_fall_s;
    logic [LINE_W-1:0]  line_lin_s, line_next_s, last_next_s;
    logic [FRAME_W-1:0] frame_count_next_s;
    logic               done_s, set_timeout_s, set_lines_s, set_seq_s;

    csi_rx_watchdog #(.W(WDOG_W)) u_watchdog (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .clear      (wd_clear_s),
        .inc        (wd_inc_s),
        .load       (1'b0),
        .load_value ({WDOG_W{1'b0}}),
        .terminal   (wd_terminal_s),
        .tc         (wd_tc_s)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r <= ST_FLUSH;
        end else if (enable) begin
            state_r <= state_next_s;
        end
    end

    // Next-state, counter control and datapath next values.
    always_comb begin
        state_next_s       = state_r;
        wd_clear_s         = 1'b0;
        wd_inc_s           = 1'b0;
        wd_terminal_s      = FRAME_TIMEOUT;
        line_rise_s        = in_line & ~in_line_q_r;
        frame_fall_s       = in_frame_q_r & ~in_frame;
        // A line edge coinciding with frame end is counted before capture.
        line_lin_s         = line_rise_s ? line_sat_inc(line_count) : line_count;
        line_next_s        = line_count;
        last_next_s        = last_line_count;
        frame_count_next_s = frame_count;
        done_s             = 1'b0;
        set_timeout_s      = 1'b0;
        set_lines_s        = 1'b0;
        set_seq_s          = 1'b0;
        case (state_r)
            ST_FLUSH: begin
                wd_terminal_s = WDOG_W'(RESYNC_CYCLES);
                if (wd_tc_s) begin
                    state_next_s = ST_ARM;
                    wd_clear_s   = 1'b1;
                end else begin
                    wd_inc_s = 1'b1;
                end
            end
            ST_ARM: begin
                wd_terminal_s = WDOG_W'(LP_SETTLE);
                if (!lp_detect) begin
                    wd_clear_s = 1'b1;
                end else if (wd_tc_s) begin
                    state_next_s = ST_WAIT_FS;
                    wd_clear_s   = 1'b1;
                end else begin
                    wd_inc_s = 1'b1;
                end
            end
            ST_WAIT_FS: begin
                wd_clear_s = 1'b1;
                if (vsync) begin
                    state_next_s = ST_FRAME;
                    line_next_s  = {LINE_W{1'b0}};
                end else begin
                    state_next_s = ST_WAIT_FS;
                end
            end
            ST_FRAME: begin
                if (payload_enable || vsync) begin
                    wd_clear_s = 1'b1;
                end else if (wd_tc_s) begin
                    set_timeout_s = 1'b1;
                end else begin
                    wd_inc_s = 1'b1;
                end
                // Timeout outranks frame end, which outranks a repeated frame start.
                if (set_timeout_s) begin
                    state_next_s = ST_FLUSH;
                    wd_clear_s   = 1'b1;
                end else if (frame_fall_s) begin
                    state_next_s       = ST_WAIT_FS;
                    wd_clear_s         = 1'b1;
                    line_next_s        = line_lin_s;
                    last_next_s        = line_lin_s;
                    frame_count_next_s = frame_count + {{(FRAME_W-1){1'b0}}, 1'b1};
                    if ((EXP_LINES != {LINE_W{1'b0}}) && (line_lin_s != EXP_LINES)) begin
                        set_lines_s = 1'b1;
                    end else begin
                        done_s = 1'b1;
                    end
                end else if (vsync) begin
                    set_seq_s   = 1'b1;
                    line_next_s = {LINE_W{1'b0}};
                end else begin
                    line_next_s = line_lin_s;
                end
            end
            default: begin
                state_next_s = ST_FLUSH;
                wd_clear_s   = 1'b1;
            end
        endcase
    end

    // Registered outputs, edge-detect history and sticky error flags.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            in_line_q_r     <= 1'b0;
            in_frame_q_r    <= 1'b0;
            rx_reset        <= 1'b1;
            frame_active    <= 1'b0;
            frame_done      <= 1'b0;
            line_count      <= {LINE_W{1'b0}};
            last_line_count <= {LINE_W{1'b0}};
            frame_count     <= {FRAME_W{1'b0}};
            err_timeout     <= 1'b0;
            err_lines       <= 1'b0;
            err_seq         <= 1'b0;
        end else if (enable) begin
            in_line_q_r     <= in_line;
            in_frame_q_r    <= in_frame;
            rx_reset        <= (state_next_s == ST_FLUSH);
            frame_active    <= (state_next_s == ST_FRAME);
            frame_done      <= done_s;
            line_count      <= line_next_s;
            last_line_count <= last_next_s;
            frame_count     <= frame_count_next_s;
            err_timeout     <= set_timeout_s | (err_timeout & ~err_clear);
            err_lines       <= set_lines_s   | (err_lines   & ~err_clear);
            err_seq         <= set_seq_s     | (err_seq     & ~err_clear);
        end
    end

endmodule

// File: tb/tb_csi_rx_link_ctrl.sv
// Directed bench for csi_rx_link_ctrl with EXP_LINES=4 and FRAME_TIMEOUT=100.
module tb_csi_rx_link_ctrl;

    logic        clock = 1'b0;
    logic        reset_n, enable, lp_detect, vsync, in_frame, in_line;
    logic        payload_enable, err_clear;
    logic        rx_reset, frame_active, frame_done;
    logic [15:0] line_count, last_line_count, frame_count;
    logic        err_timeout, err_lines, err_seq;
    int          checks = 0;
    int          errors = 0;
    int          n_rst;

    always #5 clock = ~clock;

    csi_rx_link_ctrl #(
        .LP_SETTLE     (16),
        .RESYNC_CYCLES (8),
        .FRAME_TIMEOUT (24'd100),
        .EXP_LINES     (16'd4)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .enable          (enable),
        .lp_detect       (lp_detect),
        .vsync           (vsync),
        .in_frame        (in_frame),
        .in_line         (in_line),
        .payload_enable  (payload_enable),
        .err_clear       (err_clear),
        .rx_reset        (rx_reset),
        .frame_active    (frame_active),
        .frame_done      (frame_done),
        .line_count      (line_count),
        .last_line_count (last_line_count),
        .frame_count     (frame_count),
        .err_timeout     (err_timeout),
        .err_lines       (err_lines),
        .err_seq         (err_seq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start_frame(input logic payload);
        vsync          = 1'b1;
        in_frame       = 1'b1;
        payload_enable = payload;
        tick();
        vsync = 1'b0;
    endtask

    task automatic line_pulse();
        in_line = 1'b1;
        tick();
        in_line = 1'b0;
        tick();
    endtask

    task automatic count_rx_reset(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (!rx_reset) break;
            n++;
            tick();
        end
    endtask

    task automatic arm_link();
        lp_detect = 1'b1;
        ticks(16);
        lp_detect = 1'b0;
        ticks(2);
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b1; lp_detect = 1'b0; vsync = 1'b0;
        in_frame = 1'b0; in_line = 1'b0; payload_enable = 1'b0; err_clear = 1'b0;
        ticks(3);
        chk("rst_rx_reset", 32'(rx_reset), 32'd1);
        chk("rst_frame_active", 32'(frame_active), 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        chk("rst_line_count", 32'(line_count), 32'd0);
        chk("rst_errs", 32'({err_timeout, err_lines, err_seq}), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);

        reset_n = 1'b1;
        count_rx_reset(n_rst);
        chk("flush_len", 32'(n_rst), 32'd8);

        // 15 LP cycles then a break: still in ARM, so vsync is ignored.
        lp_detect = 1'b1;
        ticks(15);
        lp_detect = 1'b0;
        tick();
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        chk("arm_15_no_frame", 32'(frame_active), 32'd0);

        // Full settle reaches WAIT_FS; dropping LP there is harmless.
        arm_link();
        chk("wait_fs_idle", 32'(frame_active), 32'd0);
        start_frame(1'b1);
        chk("fs_frame_active", 32'(frame_active), 32'd1);
        chk("fs_line_count", 32'(line_count), 32'd0);

        // Frame 1: four lines, clean end.
        for (int i = 0; i < 4; i++) line_pulse();
        chk("f1_line_count", 32'(line_count), 32'd4);
        in_frame = 1'b0;
        tick();
        chk("f1_done", 32'(frame_done), 32'd1);
        chk("f1_last", 32'(last_line_count), 32'd4);
        chk("f1_fcount", 32'(frame_count), 32'd1);
        chk("f1_errs", 32'({err_timeout, err_lines, err_seq}), 32'd0);
        chk("f1_inactive", 32'(frame_active), 32'd0);
        tick();
        chk("f1_done_pulse", 32'(frame_done), 32'd0);

        // Frame 2: fourth line rises in the same cycle as frame end.
        start_frame(1'b1);
        for (int i = 0; i < 3; i++) line_pulse();
        in_line = 1'b1; in_frame = 1'b0;
        tick();
        in_line = 1'b0;
        chk("f2_last", 32'(last_line_count), 32'd4);
        chk("f2_done", 32'(frame_done), 32'd1);
        chk("f2_fcount", 32'(frame_count), 32'd2);

        // Frame 3: only three lines.
        start_frame(1'b1);
        for (int i = 0; i < 3; i++) line_pulse();
        in_frame = 1'b0;
        tick();
        chk("f3_err_lines", 32'(err_lines), 32'd1);
        chk("f3_done", 32'(frame_done), 32'd0);
        chk("f3_fcount", 32'(frame_count), 32'd3);
        chk("f3_last", 32'(last_line_count), 32'd3);
        tick();
        chk("f3_sticky", 32'(err_lines), 32'd1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("f3_cleared", 32'(err_lines), 32'd0);

        // Frame 4: repeated frame start after two lines.
        start_frame(1'b1);
        line_pulse();
        line_pulse();
        chk("f4_two_lines", 32'(line_count), 32'd2);
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        chk("f4_err_seq", 32'(err_seq), 32'd1);
        chk("f4_line_restart", 32'(line_count), 32'd0);
        chk("f4_fcount_same", 32'(frame_count), 32'd3);
        chk("f4_still_frame", 32'(frame_active), 32'd1);
        for (int i = 0; i < 4; i++) line_pulse();
        in_frame = 1'b0;
        tick();
        chk("f4_done", 32'(frame_done), 32'd1);
        chk("f4_fcount", 32'(frame_count), 32'd4);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("f4_seq_cleared", 32'(err_seq), 32'd0);

        // Frame 5: no payload; freeze for 50 cycles mid-frame, then time out.
        start_frame(1'b0);
        line_pulse();
        enable = 1'b0; vsync = 1'b1; in_frame = 1'b0; err_clear = 1'b1;
        for (int i = 0; i < 25; i++) begin
            in_line = 1'b1; tick();
            in_line = 1'b0; tick();
        end
        chk("frz_line_count", 32'(line_count), 32'd1);
        chk("frz_frame_active", 32'(frame_active), 32'd1);
        chk("frz_frame_count", 32'(frame_count), 32'd4);
        chk("frz_outs", 32'({rx_reset, frame_done, err_timeout, err_lines, err_seq}), 32'd0);
        chk("frz_last", 32'(last_line_count), 32'd4);
        enable = 1'b1; vsync = 1'b0; in_frame = 1'b1; err_clear = 1'b0;
        ticks(97);
        chk("to_not_yet", 32'(err_timeout), 32'd0);
        chk("to_not_yet_active", 32'(frame_active), 32'd1);
        in_frame = 1'b0;
        tick();
        chk("to_err_timeout", 32'(err_timeout), 32'd1);
        chk("to_no_done", 32'(frame_done), 32'd0);
        chk("to_fcount_same", 32'(frame_count), 32'd4);
        chk("to_inactive", 32'(frame_active), 32'd0);
        count_rx_reset(n_rst);
        chk("to_flush_len", 32'(n_rst), 32'd8);
        chk("to_sticky", 32'(err_timeout), 32'd1);

        // Back in ARM: re-settle, start a frame, then reset mid-frame.
        arm_link();
        start_frame(1'b1);
        chk("rearm_frame", 32'(frame_active), 32'd1);
        line_pulse();
        reset_n = 1'b0; in_frame = 1'b0;
        tick();
        chk("mid_rst_rx_reset", 32'(rx_reset), 32'd1);
        chk("mid_rst_fcount", 32'(frame_count), 32'd0);
        chk("mid_rst_done", 32'(frame_done), 32'd0);
        chk("mid_rst_active", 32'(frame_active), 32'd0);
        chk("mid_rst_lines", 32'(line_count), 32'd0);
        reset_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
